// File: rtl/crg_triple_fifo.sv
// crg_triple_fifo: first-word-fall-through FIFO for correlated-randomness triples.
// Each entry holds {a, b, c, e} (3 x 256-bit shares plus an 8-bit extended share).
// Optional feature macro: CRG_TRIPLE_FIFO_STATS_EN adds push/drop statistics counters.
// Ports:
//   clk_i, rst_i          clock, asynchronous active-high reset
//   dvld_i, a_i..e_i      write strobe and entry payload from the generator
//   clr_i                 synchronous flush, also clears the sticky overflow flag
//   m_valid_o, m_ready_i  head-entry handshake
//   m_a_o..m_e_o          head entry (registered)
//   afull_o               registered almost-full (occupancy >= AFULL_TH)
//   ovf_o                 sticky overflow (push dropped while full)
//   level_o               current occupancy
//   push_cnt_o, drop_cnt_o  (stats build only) saturating accepted/dropped push counts
module crg_triple_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned AFULL_TH = 12
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     dvld_i,
  input  logic [255:0]             a_i,
  input  logic [255:0]             b_i,
  input  logic [255:0]             c_i,
  input  logic [7:0]               e_i,
  input  logic                     clr_i,
  output logic                     m_valid_o,
  input  logic                     m_ready_i,
  output logic [255:0]             m_a_o,
  output logic [255:0]             m_b_o,
  output logic [255:0]             m_c_o,
  output logic [7:0]               m_e_o,
  output logic                     afull_o,
  output logic                     ovf_o,
`ifdef CRG_TRIPLE_FIFO_STATS_EN
  output logic [31:0]              push_cnt_o,
  output logic [31:0]              drop_cnt_o,
`endif
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  typedef struct packed {
    logic [255:0] a;
    logic [255:0] b;
    logic [255:0] c;
    logic [7:0]   e;
  } entry_t;

  entry_t        mem [DEPTH];
  entry_t        in_entry;
  entry_t        head_q;
  entry_t        head_n;

  logic [LW-1:0] wr_q, wr_n;
  logic [LW-1:0] rd_q, rd_n;
  logic [LW-1:0] level_q, level_n;
  logic          valid_q;
  logic          ovf_q, ovf_n;
  logic          afull_q;

  logic          full_c;
  logic          pop_c;
  logic          push_ok_c;
  logic          drop_c;

  assign in_entry = '{a: a_i, b: b_i, c: c_i, e: e_i};

  // Full when indices match but the wrap bits differ.
  assign full_c    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop_c     = valid_q & m_ready_i;
  // A push while full is still accepted if the head leaves in the same cycle.
  assign push_ok_c = dvld_i & (~full_c | pop_c);
  assign drop_c    = dvld_i & full_c & ~pop_c;

  // Next-state computation; clr_i overrides push and pop.
  always_comb begin
    wr_n    = wr_q;
    rd_n    = rd_q;
    level_n = level_q;
    ovf_n   = ovf_q;
    head_n  = head_q;
    if (clr_i) begin
      wr_n    = '0;
      rd_n    = '0;
      level_n = '0;
      ovf_n   = 1'b0;
    end else begin
      if (push_ok_c) wr_n = wr_q + LW'(1);
      if (pop_c)     rd_n = rd_q + LW'(1);
      level_n = level_q + LW'(push_ok_c) - LW'(pop_c);
      if (drop_c)    ovf_n = 1'b1;
      // The slot that becomes head is being written right now: forward the input.
      if (push_ok_c && (wr_q[AW-1:0] == rd_n[AW-1:0])) head_n = in_entry;
      else                                             head_n = mem[rd_n[AW-1:0]];
    end
  end

  // Control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      level_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      afull_q <= 1'b0;
    end else begin
      wr_q    <= wr_n;
      rd_q    <= rd_n;
      level_q <= level_n;
      valid_q <= (level_n != '0);
      ovf_q   <= ovf_n;
      afull_q <= (level_q >= LW'(AFULL_TH));
    end
  end

  // Storage and head register carry no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok_c && !clr_i) mem[wr_q[AW-1:0]] <= in_entry;
    head_q <= head_n;
  end

`ifdef CRG_TRIPLE_FIFO_STATS_EN
  logic [31:0] push_cnt_q;
  logic [31:0] drop_cnt_q;

  // Saturating statistics counters.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      push_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else if (clr_i) begin
      push_cnt_q <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (push_ok_c && (push_cnt_q != '1)) push_cnt_q <= push_cnt_q + 32'd1;
      if (drop_c && (drop_cnt_q != '1))    drop_cnt_q <= drop_cnt_q + 32'd1;
    end
  end

  assign push_cnt_o = push_cnt_q;
  assign drop_cnt_o = drop_cnt_q;
`endif

  assign m_valid_o = valid_q;
  assign m_a_o     = head_q.a;
  assign m_b_o     = head_q.b;
  assign m_c_o     = head_q.c;
  assign m_e_o     = head_q.e;
  assign afull_o   = afull_q;
  assign ovf_o     = ovf_q;
  assign level_o   = level_q;

endmodule

// File: tb/tb_crg_triple_fifo.sv
// Self-checking bench for crg_triple_fifo: directed table, hand-written corner
// sequences and randomized traffic compared against a queue-based reference model.
module tb_crg_triple_fifo;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned AFULL_TH = 12;
  localparam int unsigned LW       = $clog2(DEPTH) + 1;

  logic           clk_i = 1'b0;
  logic           rst_i;
  logic           dvld_i;
  logic [255:0]   a_i, b_i, c_i;
  logic [7:0]     e_i;
  logic           clr_i;
  logic           m_valid_o;
  logic           m_ready_i;
  logic [255:0]   m_a_o, m_b_o, m_c_o;
  logic [7:0]     m_e_o;
  logic           afull_o;
  logic           ovf_o;
  logic [LW-1:0]  level_o;
`ifdef CRG_TRIPLE_FIFO_STATS_EN
  logic [31:0]    push_cnt_o, drop_cnt_o;
`endif

  crg_triple_fifo #(.DEPTH(DEPTH), .AFULL_TH(AFULL_TH)) dut (
`ifdef CRG_TRIPLE_FIFO_STATS_EN
    .push_cnt_o (push_cnt_o),
    .drop_cnt_o (drop_cnt_o),
`endif
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .dvld_i     (dvld_i),
    .a_i        (a_i),
    .b_i        (b_i),
    .c_i        (c_i),
    .e_i        (e_i),
    .clr_i      (clr_i),
    .m_valid_o  (m_valid_o),
    .m_ready_i  (m_ready_i),
    .m_a_o      (m_a_o),
    .m_b_o      (m_b_o),
    .m_c_o      (m_c_o),
    .m_e_o      (m_e_o),
    .afull_o    (afull_o),
    .ovf_o      (ovf_o),
    .level_o    (level_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model: a queue of whole entries plus the flag state.
  logic [775:0] mq[$];
  bit           ovf_m;
  bit           afull_m;
  int           push_m, drop_m;

  task automatic chk(input string nm, input logic [775:0] got, input logic [775:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic rnd_data();
    a_i = rnd256(); b_i = rnd256(); c_i = rnd256(); e_i = 8'($urandom);
  endtask

  task automatic model_reset();
    mq.delete(); ovf_m = 0; afull_m = 0; push_m = 0; drop_m = 0;
  endtask

  // Apply the FIFO rules to the inputs present at the coming edge.
  task automatic model_update();
    int sz;
    bit pop;
    sz      = mq.size();
    pop     = (sz != 0) && m_ready_i;
    afull_m = (sz >= int'(AFULL_TH));
    if (clr_i) begin
      mq.delete(); ovf_m = 0; push_m = 0; drop_m = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (dvld_i) begin
        if (sz == int'(DEPTH) && !pop) begin
          ovf_m = 1; drop_m++;
        end else begin
          mq.push_back({a_i, b_i, c_i, e_i}); push_m++;
        end
      end
    end
  endtask

  task automatic tick();
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  task automatic check_all(input string nm);
    chk({nm, ".level"}, level_o, mq.size());
    chk({nm, ".valid"}, m_valid_o, mq.size() != 0);
    chk({nm, ".ovf"}, ovf_o, ovf_m);
    chk({nm, ".afull"}, afull_o, afull_m);
    if (mq.size() != 0) chk({nm, ".head"}, {m_a_o, m_b_o, m_c_o, m_e_o}, mq[0]);
`ifdef CRG_TRIPLE_FIFO_STATS_EN
    chk({nm, ".push_cnt"}, push_cnt_o, push_m);
    chk({nm, ".drop_cnt"}, drop_cnt_o, drop_m);
`endif
  endtask

  task automatic idle();
    dvld_i = 0; m_ready_i = 0; clr_i = 0;
  endtask

  task automatic do_clr();
    idle(); clr_i = 1; tick(); clr_i = 0; check_all("clr");
  endtask

  typedef struct {
    bit dvld; bit rdy; bit clr;
    int lvl;  bit vld; bit ovf;
  } vec_t;

  initial begin
    vec_t         tbl[8];
    logic [775:0] stream[40];
    int           sent, got;

    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t         tbl[8];
    logic [775:0] stream[40];
    int           sent, got;

    tbl[0] = '{1, 0, 0, 1, 1, 0};
    tbl[1] = '{1, 0, 0, 2, 1, 0};
    tbl[2] = '{1, 1, 0, 2, 1, 0};
    tbl[3] = '{0, 1, 0, 1, 1, 0};
    tbl[4] = '{0, 1, 0, 0, 0, 0};
    tbl[5] = '{0, 1, 0, 0, 0, 0};
    tbl[6] = '{1, 0, 0, 1, 1, 0};
    tbl[7] = '{1, 0, 1, 0, 0, 0};

    // Reset state.
    rst_i = 1; idle(); rnd_data(); model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst.level", level_o, 0);
    chk("rst.valid", m_valid_o, 0);
    chk("rst.afull", afull_o, 0);
    chk("rst.ovf", ovf_o, 0);
    rst_i = 0;
    tick(); check_all("post_rst");

    // Directed table.
    for (int i = 0; i < 8; i++) begin
      dvld_i = tbl[i].dvld; m_ready_i = tbl[i].rdy; clr_i = tbl[i].clr; rnd_data();
      tick();
      chk($sformatf("tbl%0d.level", i), level_o, tbl[i].lvl);
      chk($sformatf("tbl%0d.valid", i), m_valid_o, tbl[i].vld);
      chk($sformatf("tbl%0d.ovf", i), ovf_o, tbl[i].ovf);
      check_all($sformatf("tbl%0d", i));
    end
    idle();

    // Single push, held head for 10 cycles.
    do_clr();
    dvld_i = 1; a_i = 256'd1; b_i = 256'd2; c_i = 256'd3; e_i = 8'h5A;
    tick(); idle(); rnd_data();
    chk("one.valid", m_valid_o, 1);
    for (int i = 0; i < 10; i++) begin
      chk("one.hold", {m_a_o, m_b_o, m_c_o, m_e_o}, {256'd1, 256'd2, 256'd3, 8'h5A});
      tick();
    end

    // Fill to full, almost-full timing, then overflow.
    do_clr();
    for (int i = 0; i < 16; i++) begin
      dvld_i = 1; rnd_data(); tick();
      chk("fill.level", level_o, i + 1);
      chk("fill.afull", afull_o, i >= 12);
      check_all("fill");
    end
    dvld_i = 1; rnd_data(); tick(); idle();
    chk("ovf.level", level_o, 16);
    chk("ovf.flag", ovf_o, 1);
`ifdef CRG_TRIPLE_FIFO_STATS_EN
    chk("ovf.drop_cnt", drop_cnt_o, 1);
`endif
    check_all("ovf");

    // Full FIFO with simultaneous push and pop.
    do_clr();
    for (int i = 0; i < 16; i++) begin
      dvld_i = 1; rnd_data(); tick();
    end
    for (int i = 0; i < 20; i++) begin
      dvld_i = 1; m_ready_i = 1; rnd_data(); tick();
      chk("fullpp.level", level_o, 16);
      chk("fullpp.ovf", ovf_o, 0);
      check_all("fullpp");
    end
    idle();

    // Stream of 40 entries, generator throttled by afull_o, ready toggling.
    do_clr();
    for (int i = 0; i < 40; i++) stream[i] = {rnd256(), rnd256(), rnd256(), 8'($urandom)};
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 400 && got < 40; cyc++) begin
      dvld_i = !afull_o && sent < 40;
      {a_i, b_i, c_i, e_i} = stream[sent < 40 ? sent : 39];
      m_ready_i = cyc[0];
      if (m_valid_o && m_ready_i) begin
        chk("stream.order", {m_a_o, m_b_o, m_c_o, m_e_o}, stream[got]);
        got++;
      end
      if (dvld_i) sent++;
      tick();
      check_all("stream");
    end
    chk("stream.count", got, 40);
    chk("stream.ovf", ovf_o, 0);
    idle();

    // Randomized traffic.
    do_clr();
    for (int i = 0; i < 400; i++) begin
      dvld_i = ($urandom_range(0, 3) != 0);
      m_ready_i = ($urandom_range(0, 2) != 0);
      clr_i = ($urandom_range(0, 60) == 0);
      rnd_data();
      tick();
      check_all("rand");
    end
    idle();

    // Clear at level 5 with a simultaneous push.
    do_clr();
    for (int i = 0; i < 5; i++) begin
      dvld_i = 1; rnd_data(); tick();
    end
    chk("clr5.pre", level_o, 5);
    dvld_i = 1; clr_i = 1; rnd_data(); tick(); idle();
    chk("clr5.level", level_o, 0);
    chk("clr5.valid", m_valid_o, 0);
    chk("clr5.ovf", ovf_o, 0);
    check_all("clr5");

    // Asynchronous reset pulse mid-cycle at level 7.
    for (int i = 0; i < 7; i++) begin
      dvld_i = 1; rnd_data(); tick();
    end
    idle();
    chk("arst.pre", level_o, 7);
    #2 rst_i = 1;
    #1;
    chk("arst.level", level_o, 0);
    chk("arst.valid", m_valid_o, 0);
    chk("arst.ovf", ovf_o, 0);
    chk("arst.afull", afull_o, 0);
    #1 rst_i = 0;
    model_reset();
    dvld_i = 1; rnd_data(); tick(); idle();
    chk("arst.push_valid", m_valid_o, 1);
    check_all("arst.push");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
